tiny_dnn_seq: RTL and testbench

- Host-side sequencer that drives the tiny_dnn_top accelerator port: write, init, exec, a, d in, x out.
- Turns stream commands into the accelerator's cycle protocol:
  - weight load into one filter bank;
  - accumulate-run over N input words;
  - readback of all 16 filter sums as an output stream.
- Sits between the DMA/stream fabric and tiny_dnn_top; owns all accelerator timing.

---
 rtl/tiny_dnn_seq.sv | 155 +++++++++++++++
 tb/tb_tiny_dnn_seq.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_dnn_seq.sv
// Host-side sequencer for the tiny_dnn_top accelerator port: weight load, accumulate-run, readback.
// Optional build macro TINY_DNN_SEQ_RELU_EN clamps negative readback sums to +0.0.
module tiny_dnn_seq #(
    parameter int unsigned F_NUM  = 16,
    parameter int unsigned F_SIZE = 512
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      cmd_valid,
    output logic                                      cmd_ready,
    input  logic                                      cmd_op,
    input  logic [$clog2(F_NUM)-1:0]                  cmd_filt,
    input  logic [$clog2(F_SIZE)-1:0]                 cmd_len,
    input  logic                                      s_valid,
    output logic                                      s_ready,
    input  logic [31:0]                               s_data,
    output logic                                      m_valid,
    input  logic                                      m_ready,
    output logic [31:0]                               m_data,
    output logic                                      m_last,
    output logic                                      busy,
    output logic                                      acc_write,
    output logic                                      acc_init,
    output logic                                      acc_exec,
    output logic [$clog2(F_NUM)+$clog2(F_SIZE)-1:0]   acc_a,
    output logic [31:0]                               acc_d,
    input  logic [31:0]                               acc_x
);

    localparam int unsigned FW = $clog2(F_NUM);
    localparam int unsigned IW = $clog2(F_SIZE);

    typedef enum logic [2:0] {StIdle, StLoad, StInit, StExec, StDrain, StRead} state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   filt_q, filt_d;
    logic [IW-1:0]   len_q, len_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [FW-1:0]   k_q, k_d;
    logic            drain_q, drain_d;
    logic            rd_vld_q, rd_vld_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            filt_q   <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            k_q      <= '0;
            drain_q  <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            filt_q   <= filt_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            k_q      <= k_d;
            drain_q  <= drain_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        filt_d    = filt_q;
        len_d     = len_q;
        idx_d     = idx_q;
        k_d       = k_q;
        drain_d   = drain_q;
        rd_vld_d  = rd_vld_q;
        cmd_ready = 1'b0;
        s_ready   = 1'b0;
        acc_write = 1'b0;
        acc_init  = 1'b0;
        acc_exec  = 1'b0;
        acc_a     = '0;
        acc_d     = '0;
        m_valid   = 1'b0;
        m_last    = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    filt_d  = cmd_filt;
                    len_d   = cmd_len;
                    idx_d   = '0;
                    state_d = cmd_op ? StInit : StLoad;
                end
            end
            StLoad: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    acc_write = 1'b1;
                    acc_a     = {filt_q, idx_q};
                    acc_d     = s_data;
                    idx_d     = idx_q + 1'b1;
                    if (idx_q == len_q) begin
                        idx_d   = '0;
                        state_d = StIdle;
                    end
                end
            end
            StInit: begin
                acc_init = 1'b1;
                state_d  = StExec;
            end
            StExec: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    acc_exec = 1'b1;
                    acc_a    = {{FW{1'b0}}, idx_q};
                    acc_d    = s_data;
                    idx_d    = idx_q + 1'b1;
                    if (idx_q == len_q) begin
                        idx_d   = '0;
                        drain_d = 1'b0;
                        state_d = StDrain;
                    end
                end
            end
            // Two idle cycles: accelerator operand register, then its registered exec enable.
            StDrain: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    k_d      = '0;
                    rd_vld_d = 1'b0;
                    state_d  = StRead;
                end
            end
            // x lags acc_a by one cycle, so each result alternates a settle cycle and a valid cycle.
            StRead: begin
                acc_a   = {k_q, {IW{1'b0}}};
                m_valid = rd_vld_q;
                m_last  = rd_vld_q && (k_q == FW'(F_NUM - 1));
                if (!rd_vld_q) begin
                    rd_vld_d = 1'b1;
                end else if (m_ready) begin
                    rd_vld_d = 1'b0;
                    k_d      = k_q + 1'b1;
                    if (k_q == FW'(F_NUM - 1)) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef TINY_DNN_SEQ_RELU_EN
    assign m_data = (rd_vld_q && !acc_x[31]) ? acc_x : 32'h0;
`else
    assign m_data = rd_vld_q ? acc_x : 32'h0;
`endif

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_tiny_dnn_seq.sv
// Self-checking bench for tiny_dnn_seq: behavioural accelerator plus result/write scoreboards.
module tb_tiny_dnn_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_op;
    logic [3:0]  cmd_filt;
    logic [8:0]  cmd_len;
    logic        s_valid, s_ready;
    logic [31:0] s_data;
    logic        m_valid, m_ready, m_last;
    logic [31:0] m_data;
    logic        busy, acc_write, acc_init, acc_exec;
    logic [12:0] acc_a;
    logic [31:0] acc_d;
    logic [31:0] acc_x;

    tiny_dnn_seq dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_filt(cmd_filt), .cmd_len(cmd_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .acc_write(acc_write), .acc_init(acc_init), .acc_exec(acc_exec),
        .acc_a(acc_a), .acc_d(acc_d), .acc_x(acc_x)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    function automatic logic [31:0] bf16(input logic [31:0] b);
        return {b[31:16], 16'h0};
    endfunction

    function automatic real f2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:0] == 31'h0) return 0.0;
        d = {b[31], 11'({3'b000, b[30:23]}) + 11'd896, b[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real v);
        logic [63:0] d;
        logic [10:0] e;
        if (v == 0.0) return 32'h0;
        d = $realtobits(v);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Behavioural accelerator: bf16 weights, operand stage + exec-enable stage, registered x.
    real         accw [16][512];
    real         accsum [16];
    logic        p1_e = 1'b0, p2_e = 1'b0;
    logic [8:0]  p1_a, p2_a;
    real         p1_d, p2_d;

    always @(posedge clk) begin
        if (acc_write) accw[acc_a[12:9]][acc_a[8:0]] <= f2r(bf16(acc_d));
        if (acc_init) begin
            for (int f = 0; f < 16; f++) accsum[f] <= 0.0;
        end else if (p2_e) begin
            for (int f = 0; f < 16; f++) accsum[f] <= accsum[f] + accw[f][p2_a] * p2_d;
        end
        p1_e  <= acc_exec;
        p1_a  <= acc_a[8:0];
        p1_d  <= f2r(bf16(acc_d));
        p2_e  <= p1_e;
        p2_a  <= p1_a;
        p2_d  <= p1_d;
        acc_x <= r2f(accsum[acc_a[12:9]]);
    end

    // Scoreboards
    logic [44:0] exp_wr [$];
    logic [32:0] exp_res [$];
    logic [31:0] shadow [16][512];
    logic [31:0] run_in [512];
    logic [31:0] beats [512];
    logic [31:0] got [64];
    int res_idx = 0;
    int cyc = 0;
    int init_cyc = 0, first_exec_cyc = 0, last_exec_cyc = 0, exec_cnt = 0;
    bit first_pending = 1'b0;

    initial begin
        logic [44:0] w;
        logic [32:0] r;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                chk("strobe_onehot", 32'($countones({acc_write, acc_init, acc_exec}) <= 1), 32'd1);
                chk("cmd_ready_vs_busy", 32'(cmd_ready), 32'(!busy));
                if (acc_write) begin
                    if (exp_wr.size() == 0) begin
                        fail_now("unexpected_write");
                    end else begin
                        w = exp_wr.pop_front();
                        chk("write_addr", 32'(acc_a), 32'(w[44:32]));
                        chk("write_data", acc_d, w[31:0]);
                    end
                end
                if (acc_init) begin
                    init_cyc      = cyc;
                    first_pending = 1'b1;
                end
                if (acc_exec) begin
                    if (first_pending) begin
                        chk("init_to_exec", 32'(cyc - init_cyc), 32'd1);
                        first_exec_cyc = cyc;
                        first_pending  = 1'b0;
                    end
                    last_exec_cyc = cyc;
                    exec_cnt++;
                end
                if (m_valid && m_ready) begin
                    if (exp_res.size() == 0) begin
                        fail_now("unexpected_result");
                    end else begin
                        r = exp_res.pop_front();
                        chk("result_data", m_data, r[31:0]);
                        chk("result_last", 32'(m_last), 32'(r[32]));
                    end
                    got[res_idx % 64] = m_data;
                    res_idx++;
                end
            end
        end
    end

    task automatic check_reset_outs(input string tag);
        chk({tag, "_acc_write"}, 32'(acc_write), 32'd0);
        chk({tag, "_acc_init"}, 32'(acc_init), 32'd0);
        chk({tag, "_acc_exec"}, 32'(acc_exec), 32'd0);
        chk({tag, "_acc_a"}, 32'(acc_a), 32'd0);
        chk({tag, "_acc_d"}, acc_d, 32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    endtask

    // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
    task automatic do_cmd(input logic op, input logic [3:0] f, input logic [8:0] len);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_filt  = f;
        cmd_len   = len;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 100);
        if (!cmd_ready) fail_now("cmd_accept");
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_beats(input int n, input int bubble_after);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            s_valid = 1'b1;
            s_data  = beats[i];
            do begin
                @(negedge clk);
                t++;
            end while (!s_ready && t < 100);
            if (!s_ready) fail_now("beat_accept");
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            if (i == bubble_after) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic load_filter(input logic [3:0] f, input int len, input logic [31:0] word);
        for (int i = 0; i <= len; i++) begin
            beats[i]     = word;
            shadow[f][i] = word;
            exp_wr.push_back({f, 9'(i), word});
        end
        do_cmd(1'b0, f, 9'(len));
        send_beats(len + 1, -1);
    endtask

    task automatic push_run(input int len);
        for (int f = 0; f < 16; f++) begin
            real s = 0.0;
            logic [31:0] e;
            for (int i = 0; i <= len; i++) s += f2r(bf16(shadow[f][i])) * f2r(bf16(run_in[i]));
            e = r2f(s);
`ifdef TINY_DNN_SEQ_RELU_EN
            if (e[31]) e = 32'h0;
`endif
            exp_res.push_back({f == 15, e});
        end
    endtask

    task automatic readback(input bit do_hold, input bit holdoff);
        for (int r = 0; r < 16; r++) begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
                if (holdoff) chk("cmd_holdoff", 32'(cmd_ready), 32'd0);
            end while (!m_valid && n < 64);
            if (!m_valid) begin
                fail_now("result_wait");
                return;
            end
            if (do_hold && r == 2) begin
                chk("hold_data", m_data, 32'h41400000);
                repeat (4) begin
                    @(negedge clk);
                    chk("hold_valid", 32'(m_valid), 32'd1);
                    chk("hold_data", m_data, 32'h41400000);
                end
                @(posedge clk);
                #1;
                m_ready = 1'b1;
                @(negedge clk);
            end
            @(posedge clk);
            #1;
            if (do_hold && r == 1) m_ready = 1'b0;
        end
    endtask

    initial begin
        int exec_base, res_base;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_filt = '0; cmd_len = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_m_data", m_data, 32'h0);
        @(posedge clk);
        #1;

        // LOAD filt=3 len=3 with literal addresses
        beats[0] = 32'h3F800000; beats[1] = 32'h40000000;
        beats[2] = 32'h40400000; beats[3] = 32'h40800000;
        exp_wr.push_back({13'h600, 32'h3F800000});
        exp_wr.push_back({13'h601, 32'h40000000});
        exp_wr.push_back({13'h602, 32'h40400000});
        exp_wr.push_back({13'h603, 32'h40800000});
        do_cmd(1'b0, 4'd3, 9'd3);
        send_beats(4, -1);
        @(negedge clk);
        chk("load_done_busy", 32'(busy), 32'd0);
        chk("load_writes_left", 32'(exp_wr.size()), 32'd0);
        @(posedge clk);
        #1;

        // Preload filter i with (i+1).0
        for (int f = 0; f < 16; f++) load_filter(4'(f), 3, r2f(real'(f + 1)));

        // RUN with bubble after beat 2, backpressure on result 2, command holdoff
        for (int i = 0; i < 4; i++) begin
            run_in[i] = 32'h3F800000;
            beats[i]  = 32'h3F800000;
        end
        push_run(3);
        exec_base = exec_cnt;
        res_base  = res_idx;
        do_cmd(1'b1, 4'd0, 9'd3);
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_filt = 4'd0; cmd_len = 9'd3;
        send_beats(4, 1);
        readback(1'b1, 1'b1);
        chk("exec_count", 32'(exec_cnt - exec_base), 32'd4);
        chk("exec_span", 32'(last_exec_cyc - first_exec_cyc), 32'd4);
        chk("result_count", 32'(res_idx - res_base), 32'd16);
        chk("lit_res0", got[res_base % 64], 32'h40800000);
        chk("lit_res1", got[(res_base + 1) % 64], 32'h41000000);
        chk("lit_res2", got[(res_base + 2) % 64], 32'h41400000);
        chk("lit_res15", got[(res_base + 15) % 64], 32'h42800000);

        // Held LOAD command is accepted right after the final result
        @(negedge clk);
        chk("holdoff_release", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        chk("holdoff_accept_busy", 32'(busy), 32'd1);
        chk("holdoff_accept_s_ready", 32'(s_ready), 32'd1);
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beats[i]     = 32'hBF800000;
            shadow[0][i] = 32'hBF800000;
            exp_wr.push_back({4'd0, 9'(i), 32'hBF800000});
        end
        @(posedge clk);
        #1;
        send_beats(4, -1);

        // Negative sum in filter 0
        for (int i = 0; i < 4; i++) beats[i] = 32'h3F800000;
        push_run(3);
        res_base = res_idx;
        do_cmd(1'b1, 4'd0, 9'd3);
        send_beats(4, -1);
        readback(1'b0, 1'b0);
`ifdef TINY_DNN_SEQ_RELU_EN
        chk("lit_relu_res0", got[res_base % 64], 32'h00000000);
`else
        chk("lit_neg_res0", got[res_base % 64], 32'hC0800000);
`endif

        // Reset in the middle of EXEC
        do_cmd(1'b1, 4'd0, 9'd3);
        send_beats(2, -1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outs("mid_exec_reset");
        exp_res.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Recovery: single-word LOAD to filter 5
        load_filter(4'd5, 0, 32'h40A00000);
        @(negedge clk);
        chk("recover_writes_left", 32'(exp_wr.size()), 32'd0);
        chk("recover_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
